matrix_scan_responder: RTL and testbench
========================================

Name: matrix_scan_responder

Overview:
Board-side counterpart of the lights-out 3x3 scanned LED/button matrix. It watches the one-hot column strobes and the active-low LED row lines, and rebuilds a confirmed 9-bit LED frame from them. It also answers column strobes by driving button-row lines for a requested key, so the game logic can be driven without physical switches. It serves as both the bench peripheral model and an on-chip frame monitor.

Parameters:
N_COLS, 3, number of scanned columns
N_ROWS, 3, number of LED/button rows
CONFIRM_SCANS, 2, identical consecutive full scans required before frame_out updates (>=1)
HOLD_SCANS, 20, full scans a key is held pressed; must be >=17 because the game debouncer needs 16 consecutive high samples plus 1
RELEASE_SCANS, 4, full scans held released after a press before the next request is accepted
TIMEOUT_CYCLES, 64, clk cycles without a completed scan before scan_timeout asserts

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
col_in  in  N_COLS  column strobes, expected one-hot
led_row_n_in  in  N_ROWS  LED row lines, active low (0 = lit)
btn_row_out  out  N_ROWS  button row lines, active high
press_valid  in  1  key press request
press_idx  in  4  key index, row-major (idx = row*N_COLS + col)
press_ready  out  1  request accepted when press_valid && press_ready
frame_out  out  N_ROWS*N_COLS  confirmed LED frame, row-major, 1 = lit
frame_valid  out  1  frame_out holds a confirmed frame
frame_changed  out  1  one-cycle pulse when frame_out updates
scan_error  out  1  sticky flag: multi-hot col_in seen
scan_timeout  out  1  no completed scan within TIMEOUT_CYCLES

Behaviour:
- Reset (async, rst=1): all registers clear; btn_row_out=0, frame_out=0, frame_valid=0, frame_changed=0, scan_error=0, scan_timeout=0, press_ready=1, FSM=IDLE.
- Column classification each cycle:
  - one-hot col_in at column c: store ~led_row_n_in[r] into shadow[r*N_COLS+c] and set seen[c].
  - col_in=0: idle; no sample is taken.
  - multi-hot col_in: no sample; clear seen and the confirm counter; set scan_error (sticky until rst).
- Scan complete: occurs in the cycle where the last column (N_COLS-1) is sampled while seen[0..N_COLS-2] are all set.
  - The scan value includes this cycle's sample. seen clears in the same cycle.
  - Scans that are out of order or partial never complete.
- Confirmation:
  - On scan complete, if scan value == candidate, confirm_cnt increments, saturating at CONFIRM_SCANS.
  - Otherwise candidate <= scan value and confirm_cnt <= 1.
  - When confirm_cnt reaches CONFIRM_SCANS and (candidate != frame_out or frame_valid=0): next cycle frame_out <= candidate, frame_valid <= 1, frame_changed pulses for 1 cycle.
  - Latency from the confirming scan's last-column cycle to the frame_out update is 1 clk.
- Timeout:
  - Counter clears on scan complete and otherwise increments, saturating.
  - At TIMEOUT_CYCLES: scan_timeout=1, frame_valid=0, confirm_cnt=0.
  - Both recover on the next completed scan; frame_valid returns only after re-confirmation.
- Press FSM, states IDLE / PRESS / RELEASE:
  - IDLE: press_ready=1. On accept with press_idx < N_ROWS*N_COLS: latch key, go to PRESS, scan counter=0. On accept with out-of-range press_idx: request is consumed and dropped; stay IDLE.
  - PRESS: press_ready=0. Count scan completes; at HOLD_SCANS go to RELEASE.
  - RELEASE: press_ready=0, no drive. At RELEASE_SCANS go to IDLE.
  - scan_timeout asserting during PRESS or RELEASE aborts to IDLE.
- btn_row_out (combinational from col_in, zero latency):
  - In PRESS, btn_row_out[key_row]=1 only while col_in is exactly one-hot at key_col. Otherwise all outputs are 0.
  - rst forces 0 immediately.
- Simultaneous events:
  - Multi-hot col_in in the same cycle as last-column timing: treated as error, no scan complete.
  - A press accept and a frame update in the same cycle proceed independently.

Decomposition:
- Package matrix_pkg holds N_COLS/N_ROWS defaults, the key index width, and the press FSM state enum. The game top shares the same package.
- One sub-module, scan_frame_capture: column classification, shadow, seen, confirm, and timeout logic. The press FSM and btn_row_out drive stay in the top.

Test Plan:
- Reset, then 2 clean scans cols 001,010,100 with led_row_n_in=110,111,011 on each column -> frame_out=9'b100_000_001 after the second scan's last column +1 clk, frame_changed one pulse, frame_valid=1.
- Scan A then differing scan B then B -> no update after A/B; update to B after the second B. A repeated identical frame produces no further frame_changed.
- col_in=011 for 1 cycle mid-scan -> scan_error=1 and stays 1; the partial scan is discarded; the next 2 clean scans confirm normally.
- col_in held 000 for 64 cycles -> scan_timeout=1, frame_valid=0; resume scanning -> timeout clears on the first scan complete, frame_valid returns after 2 scans.
- press_idx=4 accepted -> btn_row_out=3'b010 only in cycles with col_in=010, for 20 scans; then 4 scans with no drive; then press_ready=1. press_idx=12 -> accepted, no drive, press_ready stays 1.
- rst pulse during PRESS -> btn_row_out=0 in the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the lights-out matrix: default geometry, key index width
// and the press FSM state encoding.
package matrix_pkg;

    localparam int unsigned N_COLS_DEF = 3;
    localparam int unsigned N_ROWS_DEF = 3;
    localparam int unsigned KEY_IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } press_state_t;

endpackage

// File: rtl/matrix_scan_responder_if.sv
// Matrix-side bundle: column strobes and LED rows in, button rows out, plus the
// key request handshake and the confirmed-frame status seen by the host.
interface matrix_scan_responder_if
    import matrix_pkg::*;
#(
    parameter int unsigned N_COLS = N_COLS_DEF,
    parameter int unsigned N_ROWS = N_ROWS_DEF
);

    logic [N_COLS-1:0]        col_in;
    logic [N_ROWS-1:0]        led_row_n_in;
    logic [N_ROWS-1:0]        btn_row_out;
    logic                     press_valid;
    logic [KEY_IDX_W-1:0]     press_idx;
    logic                     press_ready;
    logic [N_ROWS*N_COLS-1:0] frame_out;
    logic                     frame_valid;
    logic                     frame_changed;
    logic                     scan_error;
    logic                     scan_timeout;

    // Scanner / host side
    modport master (
        output col_in, led_row_n_in, press_valid, press_idx,
        input  btn_row_out, press_ready, frame_out, frame_valid,
        input  frame_changed, scan_error, scan_timeout
    );

    // Responder side
    modport slave (
        input  col_in, led_row_n_in, press_valid, press_idx,
        output btn_row_out, press_ready, frame_out, frame_valid,
        output frame_changed, scan_error, scan_timeout
    );

endinterface

// File: rtl/scan_frame_capture.sv
// Rebuilds the LED frame from column strobes, confirms it over repeated identical
// scans, and flags multi-hot strobes and stalled scanning.
module scan_frame_capture
    import matrix_pkg::*;
#(
    parameter int unsigned N_COLS         = N_COLS_DEF,
    parameter int unsigned N_ROWS         = N_ROWS_DEF,
    parameter int unsigned CONFIRM_SCANS  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_COLS-1:0]        col_in,
    input  logic [N_ROWS-1:0]        led_row_n_in,
    output logic [N_ROWS*N_COLS-1:0] frame_out,
    output logic                     frame_valid,
    output logic                     frame_changed,
    output logic                     scan_error,
    output logic                     scan_timeout,
    output logic                     scan_done_c
);

    localparam int unsigned N_BITS = N_ROWS * N_COLS;
    localparam int unsigned CW     = $clog2(CONFIRM_SCANS + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [N_COLS-1:0] LAST_COL = {1'b1, {(N_COLS-1){1'b0}}};

    logic [N_BITS-1:0] shadow;
    logic [N_BITS-1:0] candidate;
    logic [N_COLS-1:0] seen;
    logic [CW-1:0]     confirm_cnt;
    logic [TW-1:0]     to_cnt;

    logic              col_onehot_c;
    logic              col_multi_c;
    logic [N_BITS-1:0] scan_value_c;
    logic [N_BITS-1:0] cand_nxt_c;
    logic [N_COLS-1:0] seen_nxt_c;
    logic [CW-1:0]     cnt_nxt_c;
    logic [TW-1:0]     to_nxt_c;
    logic              timeout_nxt_c;
    logic              update_c;

    // Shadow with this cycle's column folded in, so a completing scan sees its own last sample
    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        for (genvar c = 0; c < N_COLS; c++) begin : g_col
            assign scan_value_c[r*N_COLS + c] = (col_onehot_c && col_in[c])
                                              ? ~led_row_n_in[r]
                                              : shadow[r*N_COLS + c];
        end
    end

    always_comb begin
        col_onehot_c = $onehot(col_in);
        col_multi_c  = (col_in != '0) && !col_onehot_c;
        scan_done_c  = col_onehot_c && col_in[N_COLS-1] && (&(seen | LAST_COL));

        seen_nxt_c = seen;
        if (col_multi_c || scan_done_c) begin
            seen_nxt_c = '0;
        end else if (col_onehot_c) begin
            seen_nxt_c = seen | col_in;
        end

        to_nxt_c = to_cnt;
        if (scan_done_c) begin
            to_nxt_c = '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_nxt_c = to_cnt + TW'(1);
        end
        timeout_nxt_c = (to_nxt_c == TW'(TIMEOUT_CYCLES));

        cand_nxt_c = candidate;
        cnt_nxt_c  = confirm_cnt;
        if (col_multi_c) begin
            cnt_nxt_c = '0;
        end else if (scan_done_c) begin
            if (scan_value_c == candidate) begin
                if (confirm_cnt != CW'(CONFIRM_SCANS)) begin
                    cnt_nxt_c = confirm_cnt + CW'(1);
                end
            end else begin
                cand_nxt_c = scan_value_c;
                cnt_nxt_c  = CW'(1);
            end
        end
        if (timeout_nxt_c) begin
            cnt_nxt_c = '0;
        end

        // Publish on the confirming scan itself, giving one clock of latency
        update_c = (cnt_nxt_c == CW'(CONFIRM_SCANS))
                && ((cand_nxt_c != frame_out) || !frame_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= '0;
            candidate     <= '0;
            seen          <= '0;
            confirm_cnt   <= '0;
            to_cnt        <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            scan_error    <= 1'b0;
            scan_timeout  <= 1'b0;
        end else begin
            shadow        <= scan_value_c;
            candidate     <= cand_nxt_c;
            seen          <= seen_nxt_c;
            confirm_cnt   <= cnt_nxt_c;
            to_cnt        <= to_nxt_c;
            scan_timeout  <= timeout_nxt_c;
            scan_error    <= scan_error | col_multi_c;
            frame_changed <= update_c;
            if (update_c) begin
                frame_out <= cand_nxt_c;
            end
            if (timeout_nxt_c) begin
                frame_valid <= 1'b0;
            end else if (update_c) begin
                frame_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_scan_responder.sv
// Board-side model of the scanned LED/button matrix: monitors the LED frame and
// answers column strobes with button rows for a requested key.
module matrix_scan_responder
    import matrix_pkg::*;
#(
    parameter int unsigned N_COLS         = N_COLS_DEF,
    parameter int unsigned N_ROWS         = N_ROWS_DEF,
    parameter int unsigned CONFIRM_SCANS  = 2,
    parameter int unsigned HOLD_SCANS     = 20,
    parameter int unsigned RELEASE_SCANS  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  rst,
    matrix_scan_responder_if.slave bus
);

    localparam int unsigned SCAN_MAX = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
    localparam int unsigned SW       = $clog2(SCAN_MAX + 1);

    press_state_t      state;
    logic [N_ROWS-1:0] key_row;
    logic [N_COLS-1:0] key_col;
    logic [SW-1:0]     scan_cnt;
    logic              press_ready;
    logic              scan_done_c;
    logic              scan_timeout;

    logic [N_ROWS-1:0][N_COLS-1:0] key_hit_c;
    logic [N_COLS-1:0][N_ROWS-1:0] key_hit_t_c;
    logic [N_ROWS-1:0]             key_row_c;
    logic [N_COLS-1:0]             key_col_c;
    logic                          key_valid_c;
    logic [N_ROWS-1:0]             btn_row_c;

    scan_frame_capture #(
        .N_COLS         (N_COLS),
        .N_ROWS         (N_ROWS),
        .CONFIRM_SCANS  (CONFIRM_SCANS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_capture (
        .clk           (clk),
        .rst           (rst),
        .col_in        (bus.col_in),
        .led_row_n_in  (bus.led_row_n_in),
        .frame_out     (bus.frame_out),
        .frame_valid   (bus.frame_valid),
        .frame_changed (bus.frame_changed),
        .scan_error    (bus.scan_error),
        .scan_timeout  (scan_timeout),
        .scan_done_c   (scan_done_c)
    );

    // Row-major key decode into one-hot row/column; out-of-range indices hit nothing
    for (genvar r = 0; r < N_ROWS; r++) begin : g_key_row
        for (genvar c = 0; c < N_COLS; c++) begin : g_key_col
            assign key_hit_c[r][c]   = (bus.press_idx == KEY_IDX_W'(r*N_COLS + c));
            assign key_hit_t_c[c][r] = key_hit_c[r][c];
        end
        assign key_row_c[r] = |key_hit_c[r];
    end
    for (genvar c = 0; c < N_COLS; c++) begin : g_key_col_or
        assign key_col_c[c] = |key_hit_t_c[c];
    end
    assign key_valid_c = |key_hit_c;

    // Press sequencer: hold the key for HOLD_SCANS scans, then stay released for RELEASE_SCANS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            press_ready <= 1'b1;
            key_row     <= '0;
            key_col     <= '0;
            scan_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.press_valid && press_ready && key_valid_c) begin
                        state       <= ST_PRESS;
                        press_ready <= 1'b0;
                        key_row     <= key_row_c;
                        key_col     <= key_col_c;
                        scan_cnt    <= '0;
                    end
                end
                ST_PRESS: begin
                    if (scan_timeout) begin
                        state       <= ST_IDLE;
                        press_ready <= 1'b1;
                    end else if (scan_done_c) begin
                        if (scan_cnt == SW'(HOLD_SCANS - 1)) begin
                            state    <= ST_RELEASE;
                            scan_cnt <= '0;
                        end else begin
                            scan_cnt <= scan_cnt + SW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_timeout) begin
                        state       <= ST_IDLE;
                        press_ready <= 1'b1;
                    end else if (scan_done_c) begin
                        if (scan_cnt == SW'(RELEASE_SCANS - 1)) begin
                            state       <= ST_IDLE;
                            press_ready <= 1'b1;
                            scan_cnt    <= '0;
                        end else begin
                            scan_cnt <= scan_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    press_ready <= 1'b1;
                end
            endcase
        end
    end

    // Zero-latency answer to the strobe; key_col is one-hot so equality means exactly one-hot
    always_comb begin
        btn_row_c = '0;
        if (!rst && (state == ST_PRESS) && (bus.col_in == key_col)) begin
            btn_row_c = key_row;
        end
    end

    assign bus.btn_row_out  = btn_row_c;
    assign bus.press_ready  = press_ready;
    assign bus.scan_timeout = scan_timeout;

endmodule

// File: tb/tb_matrix_scan_responder.sv
// Directed bench for matrix_scan_responder: expected frames and button rows are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_matrix_scan_responder;

    typedef struct {
        logic [8:0] frame;
        int         cyc;
    } frame_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    frame_exp_t frm_q[$];
    logic [2:0] btn_q[$];
    logic [2:0] exp_key_col;
    logic [2:0] exp_key_row;

    matrix_scan_responder_if #(.N_COLS(3), .N_ROWS(3)) bus ();

    matrix_scan_responder #(
        .N_COLS(3), .N_ROWS(3), .CONFIRM_SCANS(2),
        .HOLD_SCANS(20), .RELEASE_SCANS(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock with the given strobe/LED rows; queues the button rows this cycle must show
    task automatic step(input logic [2:0] col, input logic [2:0] led);
        bus.col_in       = col;
        bus.led_row_n_in = led;
        btn_q.push_back((col == exp_key_col) ? exp_key_row : 3'b000);
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [2:0] l0, input logic [2:0] l1, input logic [2:0] l2);
        step(3'b001, l0);
        step(3'b010, l1);
        step(3'b100, l2);
    endtask

    // Call right after the confirming scan: the pulse must show in this very cycle
    task automatic expect_frame(input logic [8:0] f);
        frame_exp_t e;
        e.frame = f;
        e.cyc   = cyc;
        frm_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " frame_out"},     32'(bus.frame_out),     32'h0);
        check({tag, " frame_valid"},   32'(bus.frame_valid),   32'h0);
        check({tag, " frame_changed"}, 32'(bus.frame_changed), 32'h0);
        check({tag, " scan_error"},    32'(bus.scan_error),    32'h0);
        check({tag, " scan_timeout"},  32'(bus.scan_timeout),  32'h0);
        check({tag, " press_ready"},   32'(bus.press_ready),   32'h1);
        check({tag, " btn_row_out"},   32'(bus.btn_row_out),   32'h0);
    endtask

    // Monitor: button rows every scoreboarded cycle, frames on every frame_changed pulse
    initial begin
        frame_exp_t f;
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (btn_q.size() != 0) begin
                    e = btn_q.pop_front();
                    check("btn_row_out", 32'(bus.btn_row_out), 32'(e));
                end
                if (bus.frame_changed) begin
                    if (frm_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_changed: unexpected pulse with frame_out=%0h, none expected (cycle %0d)",
                                 bus.frame_out, cyc);
                    end else begin
                        f = frm_q.pop_front();
                        check("frame_out",     32'(bus.frame_out),   32'(f.frame));
                        check("frame_valid",   32'(bus.frame_valid), 32'h1);
                        check("frame_latency", 32'(cyc),             32'(f.cyc));
                    end
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.col_in       = 3'b000;
        bus.led_row_n_in = 3'b111;
        bus.press_valid  = 1'b0;
        bus.press_idx    = 4'd0;
        exp_key_col      = 3'b000;
        exp_key_row      = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Two identical scans confirm frame 100_000_001
        scan(3'b110, 3'b111, 3'b011);
        check("single scan no frame", 32'(bus.frame_valid), 32'h0);
        scan(3'b110, 3'b111, 3'b011);
        expect_frame(9'h101);
        step(3'b000, 3'b111);
        check("frame1 held", 32'(bus.frame_out), 32'h101);

        // A then B then B: only the second B publishes; repeats stay quiet
        scan(3'b111, 3'b101, 3'b111);
        scan(3'b011, 3'b111, 3'b110);
        check("A/B no update", 32'(bus.frame_out), 32'h101);
        scan(3'b011, 3'b111, 3'b110);
        expect_frame(9'h044);
        scan(3'b011, 3'b111, 3'b110);
        scan(3'b011, 3'b111, 3'b110);
        check("frame B held", 32'(bus.frame_out), 32'h044);

        // Multi-hot strobe mid-scan discards the partial scan and latches scan_error
        step(3'b001, 3'b110);
        step(3'b010, 3'b111);
        step(3'b011, 3'b000);
        check("scan_error set", 32'(bus.scan_error), 32'h1);
        step(3'b100, 3'b011);
        scan(3'b110, 3'b111, 3'b011);
        check("partial scan discarded", 32'(bus.frame_out), 32'h044);
        scan(3'b110, 3'b111, 3'b011);
        expect_frame(9'h101);
        check("scan_error sticky", 32'(bus.scan_error), 32'h1);

        // 63 idle cycles stay clear, the 64th raises scan_timeout
        repeat (63) step(3'b000, 3'b111);
        check("no timeout at 63", 32'(bus.scan_timeout), 32'h0);
        check("valid before timeout", 32'(bus.frame_valid), 32'h1);
        step(3'b000, 3'b111);
        check("timeout at 64", 32'(bus.scan_timeout), 32'h1);
        check("timeout drops valid", 32'(bus.frame_valid), 32'h0);
        scan(3'b110, 3'b111, 3'b011);
        check("timeout cleared", 32'(bus.scan_timeout), 32'h0);
        check("valid needs reconfirm", 32'(bus.frame_valid), 32'h0);
        scan(3'b110, 3'b111, 3'b011);
        expect_frame(9'h101);

        // Key 4 (row 1, col 1): drive for 20 scans, release for 4
        check("ready before press", 32'(bus.press_ready), 32'h1);
        bus.press_valid = 1'b1;
        bus.press_idx   = 4'd4;
        step(3'b000, 3'b111);
        bus.press_valid = 1'b0;
        check("ready low in press", 32'(bus.press_ready), 32'h0);
        exp_key_col = 3'b010;
        exp_key_row = 3'b010;
        repeat (19) scan(3'b110, 3'b111, 3'b011);
        check("ready low scan 19", 32'(bus.press_ready), 32'h0);
        scan(3'b110, 3'b111, 3'b011);
        exp_key_col = 3'b000;
        exp_key_row = 3'b000;
        repeat (3) scan(3'b110, 3'b111, 3'b011);
        check("ready low in release", 32'(bus.press_ready), 32'h0);
        scan(3'b110, 3'b111, 3'b011);
        check("ready after release", 32'(bus.press_ready), 32'h1);

        // Out-of-range key is consumed without any drive
        bus.press_valid = 1'b1;
        bus.press_idx   = 4'd12;
        step(3'b000, 3'b111);
        bus.press_valid = 1'b0;
        check("idx12 ready", 32'(bus.press_ready), 32'h1);
        scan(3'b110, 3'b111, 3'b011);
        check("idx12 still idle", 32'(bus.press_ready), 32'h1);

        // Reset during a press kills the drive immediately
        bus.press_valid = 1'b1;
        bus.press_idx   = 4'd4;
        step(3'b000, 3'b111);
        bus.press_valid = 1'b0;
        exp_key_col = 3'b010;
        exp_key_row = 3'b010;
        scan(3'b110, 3'b111, 3'b011);
        bus.col_in       = 3'b010;
        bus.led_row_n_in = 3'b111;
        #1;
        check("drive before rst", 32'(bus.btn_row_out), 32'h2);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-press rst");
        @(posedge clk);
        #1;
        bus.col_in  = 3'b000;
        exp_key_col = 3'b000;
        exp_key_row = 3'b000;
        rst = 1'b0;
        step(3'b010, 3'b111);
        check("ready after rst", 32'(bus.press_ready), 32'h1);

        step(3'b000, 3'b111);
        check("frame queue drained", 32'(frm_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
